fas_peak_analyzer: RTL and testbench
====================================

// Module: fas_peak_analyzer
// PURPOSE
//   Parametrised spectrum analysis stage for the FAS chain. Consumes one FFT frame of NPTS complex
//   bins streamed one per cycle (valid/ready) and computes |re|^2+|im|^2 per bin. Reports the
//   peak-power bin index, its power and a threshold-hit flag. Replaces the fixed 16-point parallel
//   analysis with a configurable-depth streaming one that supports frame checking.
// PARAMETERS
//   DW      16  width of each signed bin component (Q8.8)
//   NPTS    16  bins per frame, power of two, >= 4
//   IDXW    $clog2(NPTS)  bin index width (derived, do not override)
//   SKIP_DC 1   1: bin 0 excluded from the peak search; 0: included
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-low reset
//   bin_valid  in   1       bin_re/bin_im/bin_last valid
//   bin_ready  out  1       block can accept a bin this cycle
//   bin_re     in   DW      signed real part
//   bin_im     in   DW      signed imaginary part
//   bin_last   in   1       final bin of frame
//   thresh     in   2*DW    unsigned power threshold, sampled in DONE cycle
//   done       out  1       one-cycle pulse: results valid
//   freq       out  IDXW    index of peak bin
//   peak_pwr   out  2*DW    unsigned power of peak bin
//   hit        out  1       peak_pwr >= thresh
//   frame_err  out  1       bin_last disagreed with the bin counter for this frame
// BEHAVIOUR
//   Reset (rst=0, async): state ACCUM, bin counter 0, running max 0, max index 0; done, freq,
//     peak_pwr, hit and frame_err all 0. Reset mid-frame discards the partial frame entirely.
//   FSM: ACCUM -> DRAIN (on accepted last bin) -> DRAIN2 -> DONE -> ACCUM.
//     - bin_ready = 1 only in ACCUM. A bin is accepted on a clock edge with bin_valid && bin_ready.
//     - Last bin = bin_last=1, or counter == NPTS-1 (whichever comes first).
//   Power pipeline, 2 stages: S1 registers re*re and im*im (signed DW x DW, 2*DW-bit results,
//     non-negative). S2 registers their unsigned sum, kept to 2*DW bits. Worst case
//     2*(2^(2DW-2)) = 2^(2DW-1) fits; no saturation is needed. The bin index travels with the data.
//   Compare: at S2 output, update the max when pwr > max (strict), so a tie keeps the LOWER index.
//     With SKIP_DC=1, index 0 never updates the max. The max is cleared at frame start, so an
//     all-zero frame reports freq = (SKIP_DC ? 0 : 0) and peak_pwr = 0.
//   Latency: done is high for exactly one cycle, beginning on the 3rd rising edge after the edge
//     that accepted the last bin. freq, peak_pwr, hit and frame_err update on that same edge and
//     then hold until the next done.
//   frame_err = 1 if bin_last arrived with counter < NPTS-1 (short frame; the result covers the
//     bins received), or if counter reached NPTS-1 without bin_last (frame closed anyway).
//   Bins presented during DRAIN/DRAIN2/DONE are not accepted and are not lost; the source holds
//     them until bin_ready returns. The counter wraps to 0 when the frame closes.
// STRUCTURE
//   fas_pkg: DW default, state enum {ACCUM, DRAIN, DRAIN2, DONE}, power-width function (2*DW).
//   Sub-module fas_pwr_calc: the 2-stage |z|^2 pipeline with an index side-band and a valid
//     side-band. The FSM, counter, compare and output registers stay in fas_peak_analyzer.
// TESTING
//   1. Tone: bin1 = (0x0400,0x0000), others 0, bin_last on bin 15 -> freq=1,
//      peak_pwr=0x00100000, done 3 edges after last, frame_err=0.
//   2. Tie: bins 1 and 15 = (0x0200,0x0200), others 0 -> freq=1, peak_pwr=0x00080000.
//   3. SKIP_DC=1: bin0 = (0x7FFF,0), bin3 = (0x0100,0) -> freq=3, peak_pwr=0x00010000;
//      with SKIP_DC=0 -> freq=0, peak_pwr=0x3FFF0001.
//   4. Extremes: bin5 = (0x8000,0x8000), thresh=0x80000000 -> freq=5, peak_pwr=0x80000000, hit=1;
//      with thresh=0x80000001 -> hit=0.
//   5. Short frame: bin_last on bin 9, bin7 = (0,0x0100) -> frame_err=1, freq=7. A missing
//      bin_last on bin 15 closes the frame with frame_err=1.
//   6. Back-pressure/reset: bin_valid held high across frames -> bin_ready=0 for 3 cycles after
//      each last bin and no bin lost. Pull rst low after 7 bins, then send a full tone-at-bin-2
//      frame -> single done with freq=2.

Source files
------------

// File: rtl/fas_peak_analyzer_pkg.sv
// fas_pkg: shared defaults, FSM state type and power-width helper for the FAS peak analyzer
package fas_pkg;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {ACCUM, DRAIN, DRAIN2, DONE} state_t;
    function automatic int pwr_w(input int dw);
        return 2 * dw;
    endfunction
endpackage

// File: rtl/fas_pwr_calc.sv
// fas_pwr_calc: two-stage |re|^2+|im|^2 pipeline carrying bin index and valid alongside the data
module fas_pwr_calc
    import fas_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int IDXW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DW-1:0]        re,
    input  logic [DW-1:0]        im,
    input  logic [IDXW-1:0]      in_idx,
    output logic                 out_valid,
    output logic [pwr_w(DW)-1:0] pwr,
    output logic [IDXW-1:0]      out_idx
);
    localparam int PW = pwr_w(DW);
    logic [PW-1:0]   re_x, im_x;
    logic [PW-1:0]   rr_d, rr_q, ii_d, ii_q, pwr_d, pwr_q;
    logic            v1_d, v1_q, v2_d, v2_q;
    logic [IDXW-1:0] i1_d, i1_q, i2_d, i2_q;
    always_comb begin
        re_x  = {{DW{re[DW-1]}}, re};
        im_x  = {{DW{im[DW-1]}}, im};
        rr_d  = re_x * re_x;
        ii_d  = im_x * im_x;
        v1_d  = in_valid;
        i1_d  = in_idx;
        pwr_d = rr_q + ii_q;
        v2_d  = v1_q;
        i2_d  = i1_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q  <= '0;
            ii_q  <= '0;
            v1_q  <= 1'b0;
            i1_q  <= '0;
            pwr_q <= '0;
            v2_q  <= 1'b0;
            i2_q  <= '0;
        end else begin
            rr_q  <= rr_d;
            ii_q  <= ii_d;
            v1_q  <= v1_d;
            i1_q  <= i1_d;
            pwr_q <= pwr_d;
            v2_q  <= v2_d;
            i2_q  <= i2_d;
        end
    end
    assign out_valid = v2_q;
    assign pwr       = pwr_q;
    assign out_idx   = i2_q;
endmodule

// File: rtl/fas_peak_analyzer.sv
// fas_peak_analyzer: streaming per-frame peak-power search with threshold hit and frame checking
module fas_peak_analyzer
    import fas_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int NPTS    = 16,
    parameter int SKIP_DC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bin_valid,
    output logic                    bin_ready,
    input  logic [DW-1:0]           bin_re,
    input  logic [DW-1:0]           bin_im,
    input  logic                    bin_last,
    input  logic [pwr_w(DW)-1:0]    thresh,
    output logic                    done,
    output logic [$clog2(NPTS)-1:0] freq,
    output logic [pwr_w(DW)-1:0]    peak_pwr,
    output logic                    hit,
    output logic                    frame_err
);
    localparam int IDXW = $clog2(NPTS);
    localparam int PW   = pwr_w(DW);
    state_t          state_d, state_q;
    logic [IDXW-1:0] cnt_d, cnt_q, midx_d, midx_q, freq_d, freq_q, p_idx;
    logic [PW-1:0]   max_d, max_q, peak_d, peak_q, p_pwr;
    logic            err_d, err_q, done_d, done_q, hit_d, hit_q, ferr_d, ferr_q;
    logic            accept, at_end, is_last, p_valid, upd;
    fas_pwr_calc #(.DW(DW), .IDXW(IDXW)) u_pwr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .re        (bin_re),
        .im        (bin_im),
        .in_idx    (cnt_q),
        .out_valid (p_valid),
        .pwr       (p_pwr),
        .out_idx   (p_idx)
    );
    assign bin_ready = state_q == ACCUM;
    always_comb begin
        accept  = bin_valid && bin_ready;
        at_end  = cnt_q == IDXW'(NPTS - 1);
        is_last = bin_last || at_end;
        state_d = state_q == ACCUM  ? ((accept && is_last) ? DRAIN : ACCUM) :
                  state_q == DRAIN  ? DRAIN2 :
                  state_q == DRAIN2 ? DONE : ACCUM;
        cnt_d   = accept ? (is_last ? '0 : cnt_q + IDXW'(1)) : cnt_q;
        err_d   = (accept && is_last) ? (bin_last != at_end) : err_q;
        upd     = p_valid && (p_pwr > max_q) && !((SKIP_DC != 0) && (p_idx == '0));
        max_d   = state_q == DONE ? '0 : upd ? p_pwr : max_q;
        midx_d  = state_q == DONE ? '0 : upd ? p_idx : midx_q;
        done_d  = state_q == DONE;
        freq_d  = done_d ? midx_q : freq_q;
        peak_d  = done_d ? max_q : peak_q;
        hit_d   = done_d ? (max_q >= thresh) : hit_q;
        ferr_d  = done_d ? err_q : ferr_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            max_q   <= '0;
            midx_q  <= '0;
            done_q  <= 1'b0;
            freq_q  <= '0;
            peak_q  <= '0;
            hit_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            max_q   <= max_d;
            midx_q  <= midx_d;
            done_q  <= done_d;
            freq_q  <= freq_d;
            peak_q  <= peak_d;
            hit_q   <= hit_d;
            ferr_q  <= ferr_d;
        end
    end
    assign done      = done_q;
    assign freq      = freq_q;
    assign peak_pwr  = peak_q;
    assign hit       = hit_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_fas_peak_analyzer.sv
// tb_fas_peak_analyzer: scoreboard bench driving SKIP_DC=1 and SKIP_DC=0 analyzers with the same frames
module tb_fas_peak_analyzer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bin_valid = 1'b0;
    logic        bin_last = 1'b0;
    logic [15:0] bin_re = '0;
    logic [15:0] bin_im = '0;
    logic [31:0] thresh = '0;
    logic        ready1, done1, hit1, ferr1, ready0, done0, hit0, ferr0;
    logic [3:0]  freq1, freq0;
    logic [31:0] pwr1, pwr0;
    typedef struct {
        int          cyc;
        logic [3:0]  f1, f0;
        logic [31:0] p1, p0;
        logic        h1, h0, e;
    } exp_t;
    exp_t               q[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 last_stall = 0;
    logic signed [15:0] re_a[16];
    logic signed [15:0] im_a[16];

    fas_peak_analyzer #(.DW(16), .NPTS(16), .SKIP_DC(1)) dut (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(ready1),
        .bin_re(bin_re), .bin_im(bin_im), .bin_last(bin_last), .thresh(thresh),
        .done(done1), .freq(freq1), .peak_pwr(pwr1), .hit(hit1), .frame_err(ferr1)
    );
    fas_peak_analyzer #(.DW(16), .NPTS(16), .SKIP_DC(0)) dut0 (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(ready0),
        .bin_re(bin_re), .bin_im(bin_im), .bin_last(bin_last), .thresh(thresh),
        .done(done0), .freq(freq0), .peak_pwr(pwr0), .hit(hit0), .frame_err(ferr0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done1 || done0) begin
            chk("done_sync", {63'd0, done1}, {63'd0, done0});
            if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("freq_skip1", 64'(freq1), 64'(e.f1));
                chk("pwr_skip1", 64'(pwr1), 64'(e.p1));
                chk("hit_skip1", 64'(hit1), 64'(e.h1));
                chk("ferr_skip1", 64'(ferr1), 64'(e.e));
                chk("freq_skip0", 64'(freq0), 64'(e.f0));
                chk("pwr_skip0", 64'(pwr0), 64'(e.p0));
                chk("hit_skip0", 64'(hit0), 64'(e.h0));
                chk("ferr_skip0", 64'(ferr0), 64'(e.e));
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < 16; i++) begin
            re_a[i] = '0;
            im_a[i] = '0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // nbins accepted back to back; bin_last on the final one only when with_last
    task automatic send_frame(input int nbins, input bit with_last, input bit push);
        logic [31:0] m1, m0, p;
        logic [3:0]  f1, f0;
        longint      r, m;
        int          stall;
        exp_t        e;
        m1 = '0; m0 = '0; f1 = '0; f0 = '0;
        for (int i = 0; i < nbins; i++) begin
            @(negedge clk);
            bin_valid = 1'b1;
            bin_re    = re_a[i];
            bin_im    = im_a[i];
            bin_last  = with_last && (i == nbins - 1);
            stall = 0;
            while (!ready1) begin
                @(negedge clk);
                stall++;
                if (stall > 20) begin
                    chk("ready_timeout", 64'd0, 64'd1);
                    $fatal(1, "bin_ready never returned");
                end
            end
            if (i == 0) last_stall = stall;
            @(posedge clk);
            #1;
            r = longint'(re_a[i]);
            m = longint'(im_a[i]);
            p = 32'(r * r + m * m);
            if (i != 0 && p > m1) begin m1 = p; f1 = 4'(i); end
            if (p > m0) begin m0 = p; f0 = 4'(i); end
        end
        if (push) begin
            e.cyc = cyc + 3;
            e.f1 = f1; e.p1 = m1; e.h1 = m1 >= thresh;
            e.f0 = f0; e.p0 = m0; e.h0 = m0 >= thresh;
            e.e  = !(with_last && nbins == 16);
            q.push_back(e);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_freq", 64'(freq1), 64'd0);
        chk("rst_pwr", 64'(pwr1), 64'd0);
        chk("rst_hit", 64'(hit1), 64'd0);
        chk("rst_ferr", 64'(ferr1), 64'd0);
        chk("rst_ready", 64'(ready1), 64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // tone at bin 1
        clr(); re_a[1] = 16'h0400; thresh = 32'h0010_0000;
        send_frame(16, 1, 1); idle(6);
        // tie between bins 1 and 15 keeps the lower index
        clr(); re_a[1] = 16'h0200; im_a[1] = 16'h0200; re_a[15] = 16'h0200; im_a[15] = 16'h0200;
        thresh = 32'h0010_0000;
        send_frame(16, 1, 1); idle(6);
        // strong DC bin vs small bin 3
        clr(); re_a[0] = 16'h7FFF; re_a[3] = 16'h0100; thresh = 32'h0002_0000;
        send_frame(16, 1, 1); idle(6);
        // most negative components, threshold exactly at and just above the peak
        clr(); re_a[5] = 16'h8000; im_a[5] = 16'h8000; thresh = 32'h8000_0000;
        send_frame(16, 1, 1); idle(6);
        thresh = 32'h8000_0001;
        send_frame(16, 1, 1); idle(6);
        // short frame closed by bin_last on bin 9
        clr(); im_a[7] = 16'h0100; thresh = 32'h0;
        send_frame(10, 1, 1); idle(6);
        // no bin_last: counter closes the frame
        clr(); re_a[12] = -16'sh0300;
        send_frame(16, 0, 1); idle(6);
        // random frame
        clr();
        for (int i = 0; i < 16; i++) begin
            re_a[i] = 16'($urandom);
            im_a[i] = 16'($urandom);
        end
        thresh = $urandom;
        send_frame(16, 1, 1); idle(6);
        // back-to-back frames with bin_valid held high
        clr(); re_a[4] = 16'h0123;
        send_frame(16, 1, 1);
        clr(); im_a[9] = 16'h0321;
        send_frame(16, 1, 1);
        chk("stall_cycles", 64'(last_stall), 64'd3);
        clr(); re_a[11] = 16'h0050; im_a[11] = 16'h0050;
        send_frame(16, 1, 1);
        chk("stall_cycles2", 64'(last_stall), 64'd3);
        idle(8);
        // reset mid-frame discards the partial frame
        clr(); re_a[3] = 16'h7000;
        send_frame(7, 0, 0);
        @(negedge clk);
        bin_valid = 1'b0;
        #2 rst = 1'b0;
        #2;
        chk("midrst_done", 64'(done1), 64'd0);
        chk("midrst_freq", 64'(freq1), 64'd0);
        chk("midrst_pwr", 64'(pwr1), 64'd0);
        chk("midrst_ferr", 64'(ferr1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        clr(); re_a[2] = 16'h0400;
        send_frame(16, 1, 1); idle(8);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
